// File: rtl/array_multiplier_signed_pkg.sv
// Shared widths and operand/product types for the signed array multiplier.
package array_multiplier_signed_pkg;

  localparam int unsigned MULT_WIDTH = 32;
  localparam int unsigned PROD_WIDTH = 2 * MULT_WIDTH;

  typedef logic signed [MULT_WIDTH-1:0] operand_t;
  typedef logic signed [PROD_WIDTH-1:0] product_t;

endpackage

// File: rtl/array_multiplier_signed_fa_cell.sv
// One-bit full adder. Used as a half adder by tying cin_i to 0.
module mult_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/array_multiplier_signed.sv
// Baugh-Wooley signed array multiplier: carry-save adder-cell array, ripple-carry
// final adder, and a single output register (one cycle of latency).
module array_multiplier_signed
  import array_multiplier_signed_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   p
);

  localparam int unsigned PW = 2 * WIDTH;
  // Sign-correction constant: 2^WIDTH + 2^(2*WIDTH-1)
  localparam logic [PW-1:0] CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  logic [PW-1:0] p_d;
  logic [PW-1:0] p_q;
  logic [PW-1:0] fin_s;
  logic [PW-1:0] fin_c;

  // Row r holds pp[r][j] shifted left by r; terms with exactly one index at WIDTH-1 are inverted
  for (genvar r = 0; r < WIDTH; r++) begin : g_row
    logic [PW-1:0] pp;
    for (genvar k = 0; k < PW; k++) begin : g_bit
      if (k >= r && k < r + WIDTH) begin : g_term
        localparam int unsigned J = k - r;
        if ((r == WIDTH - 1) != (J == WIDTH - 1)) begin : g_inv
          assign pp[k] = ~(a[J] & b[r]);
        end else begin : g_pos
          assign pp[k] = a[J] & b[r];
        end
      end else begin : g_zero
        assign pp[k] = 1'b0;
      end
    end
  end

  // Carry-save reduction: each stage folds one more row into the (sum, carry) pair
  for (genvar r = 0; r < WIDTH; r++) begin : g_csa
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    if (r == 0) begin : g_init
      assign s = g_row[0].pp;
      assign c = CORR;
    end else begin : g_stage
      assign c[0] = 1'b0;
      for (genvar k = 0; k < PW; k++) begin : g_col
        if (k < PW - 1) begin : g_cell
          mult_fa_cell u_fa (
            .a_i    (g_csa[r-1].s[k]),
            .b_i    (g_csa[r-1].c[k]),
            .cin_i  (g_row[r].pp[k]),
            .sum_o  (s[k]),
            .cout_o (c[k+1])
          );
        end else begin : g_msb
          // Carry out of the top bit falls outside the product and is dropped
          assign s[k] = g_csa[r-1].s[k] ^ g_csa[r-1].c[k] ^ g_row[r].pp[k];
        end
      end
    end
  end

  assign fin_s = g_csa[WIDTH-1].s;
  assign fin_c = g_csa[WIDTH-1].c;

  // Final ripple-carry adder; bit 0 is a half adder
  for (genvar k = 0; k < PW; k++) begin : g_rca
    if (k < PW - 1) begin : g_full
      logic cin;
      logic cy;
      if (k == 0) begin : g_lsb
        assign cin = 1'b0;
      end else begin : g_chain
        assign cin = g_rca[k-1].g_full.cy;
      end
      mult_fa_cell u_fa (
        .a_i    (fin_s[k]),
        .b_i    (fin_c[k]),
        .cin_i  (cin),
        .sum_o  (p_d[k]),
        .cout_o (cy)
      );
    end else begin : g_top
      assign p_d[k] = fin_s[k] ^ fin_c[k] ^ g_rca[k-1].g_full.cy;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_array_multiplier_signed.sv
// Scoreboard bench for array_multiplier_signed: directed sign/extreme cases, reset
// behaviour and random operands against a 64-bit signed arithmetic reference.
module tb_array_multiplier_signed;
  import array_multiplier_signed_pkg::*;

  logic     clk;
  logic     rst;
  operand_t a_s;
  operand_t b_s;
  product_t p_s;

  int checks;
  int errors;
  product_t exp_q[$];

  array_multiplier_signed #(.WIDTH(MULT_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a_s),
    .b   (b_s),
    .p   (p_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic product_t ref_mul(input operand_t x, input operand_t y);
    longint lx;
    longint ly;
    lx = longint'(x);
    ly = longint'(y);
    return product_t'(lx * ly);
  endfunction

  task automatic check(input string name, input product_t got, input product_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Apply operands mid-cycle; the product is due after the next rising edge
  task automatic drive(input operand_t x, input operand_t y);
    @(negedge clk);
    a_s = x;
    b_s = y;
    exp_q.push_back(ref_mul(x, y));
  endtask

  // Async reset pulse between edges, held across one edge to discard in-flight data
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_reset_async", p_s, '0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: p is checked one time unit after every rising edge
  always @(posedge clk) begin
    #1;
    if (rst) begin
      check("reset_hold", p_s, '0);
    end else if (exp_q.size() > 0) begin
      check("product", p_s, exp_q.pop_front());
    end
  end

  initial begin
    operand_t ra;
    operand_t rb;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a_s = 32'sd5;
    b_s = 32'sd7;
    #3;
    check("reset_async", p_s, '0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    drive(32'sd5, 32'sd7);
    drive(32'sd7, -32'sd9);
    drive(32'sd10, 32'sd6);
    drive(-32'sd9, -32'sd34);
    drive(32'h8000_0000, 32'h8000_0000);
    drive(32'h8000_0000, 32'h7FFF_FFFF);
    drive(-32'sd1, -32'sd1);
    drive(32'sd0, 32'hDEAD_BEEF);
    drive(32'sd1, -32'sd1);
    drive(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    drive(32'hDEAD_BEEF, 32'sd0);

    for (int i = 0; i < 10000; i++) begin
      if (i % 2500 == 1250) mid_reset();
      ra = operand_t'($urandom);
      rb = operand_t'($urandom);
      case ($urandom_range(0, 15))
        0: ra = 32'h8000_0000;
        1: rb = 32'h7FFF_FFFF;
        2: ra = -32'sd1;
        3: rb = operand_t'($urandom_range(0, 15));
        default: ;
      endcase
      drive(ra, rb);
    end

    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_drained", product_t'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/array_multiplier_signed.md
Name: array_multiplier_signed

Overview:
- 32x32 two's-complement signed multiplier producing the full 64-bit product.
- Built as a Baugh-Wooley style array of adder cells, not with the behavioural `*` operator.
- Product is captured in one output register, so the block drops into the datapath (ALU/multiply unit) as a single-cycle-latency stage.

Parameters:
- WIDTH, 32, operand width in bits; product width is 2*WIDTH. Only 32 is required to be verified.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  32  multiplicand, signed two's complement.
- b  input  32  multiplier, signed two's complement.
- p  output  64  signed product a*b, registered.

Behaviour:
- Combinational core:
  - Partial products pp[i][j] = a[j] & b[i].
  - Baugh-Wooley sign handling: invert pp terms where exactly one index equals WIDTH-1, i.e. pp[i][WIDTH-1] for i<WIDTH-1 and pp[WIDTH-1][j] for j<WIDTH-1.
  - The corner term pp[WIDTH-1][WIDTH-1] is not inverted.
  - Add correction constant 1 at bit WIDTH and 1 at bit 2*WIDTH-1.
  - Reduce rows with a ripple array of full/half adder cells; the final row is a ripple-carry adder.
  - Result is the exact 2*WIDTH-bit product; the carry out of bit 2*WIDTH-1 is discarded.
- Register:
  - p <= product(a,b) on every rising clk edge.
  - No enable and no handshake; inputs are sampled every cycle.
  - Latency is exactly 1 cycle: inputs applied before edge N appear on p after edge N.
- Reset:
  - rst high clears p to 64'h0 immediately, independent of clk.
  - p holds 0 while rst is asserted.
  - On the first rising edge after rst deasserts, p loads the product of the current a, b.
  - Reset asserted mid-stream discards the in-flight product; there is no other state.
- Arithmetic rules:
  - Full-range signed; no overflow is possible in 64 bits.
  - Product of -2^31 * -2^31 = +2^62 must be correct.
  - Zero in either operand gives 0.
  - Sign of the result follows the usual rules, including cases where either operand is negative.
- No X propagation from a defined input; p is fully defined after reset.

Decomposition:
- Shared package: MULT_WIDTH = 32 constant; product-width constant 2*MULT_WIDTH; typedefs for the signed operand and product vectors.
- One natural sub-module: mult_fa_cell, a full-adder cell (a, b, cin -> sum, cout).
  - Instantiated in generate loops to form the array.
  - Half-adder positions use the same cell with cin tied to 0.
- The output register stays in the top module.

Test Plan:
- Reset: assert rst with a=5, b=7 -> p=0 asynchronously and stays 0 while rst=1. Release rst -> next edge p=64'd35.
- Basic sign cases, one per cycle with a 1-cycle lag check:
  - a=5, b=7 -> p=35.
  - a=7, b=-9 -> p=64'hFFFF_FFFF_FFFF_FFC1 (-63).
  - a=10, b=6 -> p=60.
  - a=-9, b=-34 -> p=306.
- Extremes:
  - a=b=32'h8000_0000 -> p=64'h4000_0000_0000_0000.
  - a=32'h8000_0000, b=32'h7FFF_FFFF -> p=64'hC000_0000_8000_0000.
  - a=b=-1 -> p=1.
- Zero/identity:
  - a=0, b=32'hDEAD_BEEF -> p=0.
  - a=1, b=-1 -> p=64'hFFFF_FFFF_FFFF_FFFF.
- Mid-stream reset: stream random operands, pulse rst between edges -> p goes 0 immediately. The first post-reset edge shows the product of the operands present at that edge only.
- Random: 10k signed random pairs checked against a reference a*b computed in 64-bit signed arithmetic, compared one cycle later.
